uart_bus_ctrl: RTL and testbench
================================

# uart_bus_ctrl

Memory-mapped controller between the CPU bus and the `uart` core in `mcu`. It owns the UART's transmit handshake (`tx_start`/`tx_busy`/`tx_ready`), buffers bytes in both directions in small FIFOs, and holds the baud divisor and control/status registers. It is the only block that drives the UART's control inputs, so CPU firmware never has to sequence UART timing directly.

## Interface
- `FIFO_DEPTH`, 8: entries per FIFO; must be a power of 2, at least 2.
- `BAUD_RESET`, 16'd434: reset value of BAUD (50 MHz / 115200).
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `bus_sel`  in  1  block selected this cycle.
- `bus_we`  in  1  write strobe; only meaningful when `bus_sel` is high.
- `bus_re`  in  1  read strobe; only meaningful when `bus_sel` is high.
- `bus_addr`  in  4  byte offset; bits [1:0] are ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; registered.
- `bus_ready`  out  1  one-cycle access acknowledge.
- `irq`  out  1  registered interrupt request.
- `tx_start`  out  1  one-cycle pulse to the UART.
- `tx_data_in`  out  8  byte to transmit; held stable from the `tx_start` cycle until the next pulse.
- `tx_ready`  in  1  UART able to accept a byte.
- `tx_busy`  in  1  UART shifting a byte.
- `rx_data_out`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data_out` is valid in that cycle.
- `baud_tick_max`  out  16  equals the BAUD register.

## Operation
- **Register map**
  - 0x0 DATA: a write pushes `bus_wdata[7:0]` into the TX FIFO. A read pops the RX FIFO and returns `{24'b0, byte}`. A read of an empty RX FIFO returns 0 and pops nothing.
  - 0x4 STATUS: read-only except that the sticky bits are write-1-to-clear.
    - bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 `tx_busy`.
    - bit5 rx_overrun (sticky), bit6 tx_overflow (sticky).
  - 0x8 BAUD: read/write, bits [15:0]; upper read bits are 0.
  - 0xC CTRL: read/write.
    - bit0 tx_en, bit1 rx_en, bit2 rx_irq_en, bit3 tx_irq_en.
    - bit4 tx_flush and bit5 rx_flush self-clear and always read 0.
- **TX FIFO push**
  - Accepted if the FIFO is not full, or if the sequencer pops in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
- **RX FIFO push**
  - `rx_valid` with rx_en=1 pushes if the FIFO is not full, or if a CPU pop happens in the same cycle.
  - Otherwise the byte is dropped and rx_overrun is set.
  - `rx_valid` with rx_en=0 is ignored.
- **TX sequencer FSM**
  - IDLE → LOAD when tx_en=1, TX FIFO is non-empty and `tx_ready`=1.
  - LOAD: one cycle. Register `tx_data_in` = FIFO head, pulse `tx_start`, pop the FIFO. Go to ACK.
  - ACK: wait for `tx_busy`=1, then go to DRAIN.
  - DRAIN: wait for `tx_busy`=0, then go to IDLE.
  - Clearing tx_en only stops new LOAD entries; a byte already launched completes.
- **Flush**
  - Setting tx_flush or rx_flush empties that FIFO on the next edge.
  - The in-flight byte in ACK/DRAIN still completes.
  - A push arriving in the same cycle as its flush is discarded.
- **Interrupt:** `irq` = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty & FSM in IDLE), registered.
- **Width rules:** FIFO counts are log2(FIFO_DEPTH)+1 bits wide; read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:**
  - `bus_rdata`=0, `bus_ready`=0, `irq`=0.
  - `tx_start`=0, `tx_data_in`=0.
  - `baud_tick_max`=BAUD_RESET, CTRL=0x3, FIFOs empty, sticky bits 0, FSM in IDLE.
  - Reset asserted mid-transfer forces all of the above immediately.
- **Bus access**
  - An access in cycle N (`bus_sel`, plus `bus_we` or `bus_re`) gets `bus_ready`=1 in N+1 for exactly one cycle; for a read, `bus_rdata` is valid in N+1.
  - Reads in all other cycles hold the previous value of `bus_rdata`.
  - Write side effects (push, W1C, register update) take effect at the end of cycle N.
  - Simultaneous `bus_we` and `bus_re`: treated as a write only.
- **TX latency:** a DATA write in cycle N into an empty FIFO, with tx_en=1 and `tx_ready`=1, gives `tx_start`=1 in cycle N+2.
- **RX latency:** `rx_valid` in cycle N makes rx_nonempty visible to a STATUS read issued in N+1.

## Test plan
- **Reset defaults:** release reset, read 0x8 then 0xC → 0x000001B2, then 0x00000003. Read STATUS → 0x4 (only tx_empty set).
- **TX handshake:** write 0x41 to DATA with `tx_ready`=1 → `tx_start` pulses for 1 cycle at N+2 with `tx_data_in`=0x41. A model raising `tx_busy` for 10 cycles → next byte's `tx_start` only after `tx_busy` falls.
- **TX overflow:** hold `tx_ready`=0 and write 9 bytes → STATUS bit3=1 and bit6=1. Write 0x40 to STATUS → bit6=0.
- **RX overrun:** inject 9 `rx_valid` bytes 0x10..0x18 → rx_full=1 and rx_overrun=1. 8 DATA reads return 0x10..0x17. A ninth read returns 0.
- **Simultaneous RX on full:** with the RX FIFO full, `rx_valid` (0xAA) in the same cycle as a DATA read → read returns the oldest byte, 0xAA is stored, no overrun.
- **Mid-transfer controls:** flush/reset in DRAIN → tx_flush completes the current byte and leaves tx_empty=1. Driving `n_reset` low in DRAIN forces `tx_start`=0 and FSM in IDLE asynchronously.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// CPU bus front-end for the UART core: TX/RX byte FIFOs, BAUD/CTRL/STATUS
// registers and the sequencer that owns the tx_start/tx_busy handshake.
module uart_bus_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        irq,
    output logic        tx_start,
    output logic [7:0]  tx_data_in,
    input  logic        tx_ready,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data_out,
    input  logic        rx_valid,
    output logic [15:0] baud_tick_max
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_BAUD = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load_c;

    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wptr, r_tx_rptr;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wptr, r_rx_rptr;
    logic [CW-1:0] r_rx_cnt;

    logic [15:0]   r_baud;
    logic [3:0]    r_ctrl;
    logic          r_tx_ovf, r_rx_ovr;
    logic [31:0]   r_rdata;
    logic          r_ready, r_irq, r_tx_start;
    logic [7:0]    r_tx_data;

    logic          w_wr, w_rd;
    logic [1:0]    w_reg;
    logic          w_tx_flush, w_rx_flush;
    logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic          w_tx_push_req, w_tx_push, w_tx_pop, w_tx_drop;
    logic          w_rx_push_req, w_rx_push, w_rx_pop, w_rx_drop;
    logic [7:0]    w_tx_head, w_rx_head;
    logic [6:0]    w_status_c;
    logic [31:0]   w_rdata_c;
    logic          w_unused;

    // Bus decode; a simultaneous write and read is treated as a write only
    assign w_wr  = bus_sel & bus_we;
    assign w_rd  = bus_sel & bus_re & ~bus_we;
    assign w_reg = bus_addr[3:2];
    assign w_unused = ^{bus_addr[1:0], bus_wdata[31:16]};

    assign w_tx_flush = w_wr & (w_reg == A_CTRL) & bus_wdata[4];
    assign w_rx_flush = w_wr & (w_reg == A_CTRL) & bus_wdata[5];

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_tx_head  = r_tx_mem[r_tx_rptr];
    assign w_rx_head  = r_rx_mem[r_rx_rptr];

    // A full FIFO still accepts when the opposite side pops in the same cycle
    assign w_tx_pop      = (r_state == S_LOAD) & ~w_tx_empty;
    assign w_tx_push_req = w_wr & (w_reg == A_DATA) & ~w_tx_flush;
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_tx_drop     = w_tx_push_req & w_tx_full & ~w_tx_pop;

    assign w_rx_pop      = w_rd & (w_reg == A_DATA) & ~w_rx_empty;
    assign w_rx_push_req = rx_valid & r_ctrl[1] & ~w_rx_flush;
    assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_drop     = w_rx_push_req & w_rx_full & ~w_rx_pop;

    always_ff @(posedge clk) begin : tx_mem_wr
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk) begin : rx_mem_wr
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_out;
    end

    always_ff @(posedge clk or negedge n_reset) begin : tx_fifo_ptrs
        if (!n_reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else if (w_tx_flush) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin : rx_fifo_ptrs
        if (!n_reset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else if (w_rx_flush) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin : fsm_state
        if (!n_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A flush in the launch-decision cycle suppresses the launch so LOAD never sees an empty FIFO
    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_load_c    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0] & ~w_tx_empty & tx_ready & ~w_tx_flush) begin
                    w_state_nxt = S_LOAD;
                    w_load_c    = 1'b1;
                end
            end
            S_LOAD:  w_state_nxt = S_ACK;
            S_ACK:   if (tx_busy)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!tx_busy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin : tx_launch
        if (!n_reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_load_c;
            if (w_load_c) r_tx_data <= w_tx_head;
        end
    end

    // Sticky error bits: a new error wins over a same-cycle W1C
    always_ff @(posedge clk or negedge n_reset) begin : csr_regs
        if (!n_reset) begin
            r_baud   <= BAUD_RESET;
            r_ctrl   <= 4'h3;
            r_tx_ovf <= 1'b0;
            r_rx_ovr <= 1'b0;
        end else begin
            if (w_wr && w_reg == A_BAUD) r_baud <= bus_wdata[15:0];
            if (w_wr && w_reg == A_CTRL) r_ctrl <= bus_wdata[3:0];
            if (w_tx_drop)                                   r_tx_ovf <= 1'b1;
            else if (w_wr && w_reg == A_STAT && bus_wdata[6]) r_tx_ovf <= 1'b0;
            if (w_rx_drop)                                   r_rx_ovr <= 1'b1;
            else if (w_wr && w_reg == A_STAT && bus_wdata[5]) r_rx_ovr <= 1'b0;
        end
    end

    assign w_status_c = {r_tx_ovf, r_rx_ovr, tx_busy, w_tx_full, w_tx_empty,
                         w_rx_full, ~w_rx_empty};

    always_comb begin : read_mux
        w_rdata_c = '0;
        case (w_reg)
            A_DATA:  if (!w_rx_empty) w_rdata_c = {24'b0, w_rx_head};
            A_STAT:  w_rdata_c = {25'b0, w_status_c};
            A_BAUD:  w_rdata_c = {16'b0, r_baud};
            default: w_rdata_c = {28'b0, r_ctrl};
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin : bus_resp
        if (!n_reset) begin
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_wr | w_rd;
            if (w_rd) r_rdata <= w_rdata_c;
            r_irq <= (r_ctrl[2] & ~w_rx_empty) |
                     (r_ctrl[3] & w_tx_empty & (r_state == S_IDLE));
        end
    end

    assign bus_rdata     = r_rdata;
    assign bus_ready     = r_ready;
    assign irq           = r_irq;
    assign tx_start      = r_tx_start;
    assign tx_data_in    = r_tx_data;
    assign baud_tick_max = r_baud;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: bus reads and UART launches are checked
// against queues filled when the stimulus is driven; a small UART model drives tx_busy.
`timescale 1ns/1ps
module tb_uart_bus_ctrl;
    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_BAUD = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        bus_sel, bus_we, bus_re;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready, irq, tx_start;
    logic [7:0]  tx_data_in;
    logic        tx_ready, tx_busy;
    logic [7:0]  rx_data_out;
    logic        rx_valid;
    logic [15:0] baud_tick_max;

    logic        tb_ready;
    int unsigned busy_cnt;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        string       tag;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0;
    int last_start = -1;
    int last_fall  = -1;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;

    uart_bus_ctrl #(.FIFO_DEPTH(8), .BAUD_RESET(16'd434)) dut (
        .clk(clk), .n_reset(n_reset),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_re(bus_re),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .irq(irq),
        .tx_start(tx_start), .tx_data_in(tx_data_in),
        .tx_ready(tx_ready), .tx_busy(tx_busy),
        .rx_data_out(rx_data_out), .rx_valid(rx_valid),
        .baud_tick_max(baud_tick_max)
    );

    // UART model: busy for 10 cycles after each launch
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)            busy_cnt <= 32'd0;
        else if (tx_start)       busy_cnt <= 32'd10;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 32'd1;
    end
    assign tx_busy  = (busy_cnt != 0);
    assign tx_ready = tb_ready & ~tx_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Output monitor: pops the scoreboards whenever the DUT responds
    always @(negedge clk) begin : mon
        rd_exp_t    e;
        logic [7:0] b;
        cyc++;
        if (!n_reset) begin
            last_start = -1;
            last_fall  = -1;
            prev_busy  = 1'b0;
        end else begin
            if (prev_busy && !tx_busy) last_fall = cyc;
            prev_busy = tx_busy;
            if (tx_start) begin
                check("tx_gap", 32'(last_start < 0 || last_fall > last_start), 32'd1);
                last_start = cyc;
                if (tx_q.size() == 0) begin
                    check("tx_start_unexp", 32'(tx_start), 32'd0);
                end else begin
                    b = tx_q.pop_front();
                    check("tx_data", {24'b0, tx_data_in}, {24'b0, b});
                end
            end
            if (bus_ready) begin
                if (rd_q.size() == 0) begin
                    check("ready_unexp", 32'(bus_ready), 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    if (e.chk) check(e.tag, bus_rdata, e.data);
                end
            end
        end
    end

    task automatic bus_cycle(input logic we, input logic re, input logic [3:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp, input string tag,
                             input logic rxv, input logic [7:0] rxd);
        rd_exp_t e;
        @(negedge clk);
        bus_sel = 1'b1; bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wd;
        rx_valid = rxv; rx_data_out = rxd;
        e.chk = re & ~we; e.data = exp; e.tag = tag;
        rd_q.push_back(e);
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, addr, d, 32'd0, "wr", 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        bus_cycle(1'b0, 1'b1, addr, 32'd0, exp, tag, 1'b0, 8'h00);
    endtask

    task automatic wr_tx(input logic [7:0] b, input logic accept);
        if (accept) tx_q.push_back(b);
        wr(A_DATA, {24'hABCDEF, b});
    endtask

    task automatic rx_inject(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data_out = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        int n = 0;
        while ((tx_q.size() != 0 || tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 500), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_busy), 32'd1);
    endtask

    initial begin
        n_reset = 1'b0; tb_ready = 1'b0;
        bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
        rx_valid = 1'b0; rx_data_out = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_ready", 32'(bus_ready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", {24'b0, tx_data_in}, 32'd0);
        check("rst_baud_out", {16'b0, baud_tick_max}, 32'h1B2);
        n_reset = 1'b1;

        rd(A_BAUD, 32'h0000_01B2, "baud_rst");
        rd(A_CTRL, 32'h0000_0003, "ctrl_rst");
        rd(A_STAT, 32'h0000_0004, "stat_rst");

        wr(A_BAUD, 32'hDEAD_5678);
        rd(A_BAUD, 32'h0000_5678, "baud_rw");
        check("baud_out", {16'b0, baud_tick_max}, 32'h5678);

        // TX-empty interrupt, then disable
        wr(A_CTRL, 32'h0B);
        @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h03);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);

        // TX handshake: tx_start exactly in cycle N+2
        tb_ready = 1'b1;
        wr_tx(8'h41, 1'b1);
        check("tx_start_n1", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("tx_start_n2", 32'(tx_start), 32'd1);
        check("tx_data_n2", {24'b0, tx_data_in}, 32'h41);
        @(negedge clk);
        check("tx_start_n3", 32'(tx_start), 32'd0);
        wr_tx(8'h42, 1'b1);
        wr_tx(8'h43, 1'b1);
        wait_tx_done("tx_drain1");
        check("tx_data_hold", {24'b0, tx_data_in}, 32'h43);

        // TX overflow with the UART not ready
        tb_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr_tx(8'h80 + 8'(i), i < 8);
        rd(A_STAT, 32'h48, "stat_tx_ovf");
        wr(A_STAT, 32'h40);
        rd(A_STAT, 32'h08, "stat_ovf_clr");
        tb_ready = 1'b1;
        wait_tx_done("tx_drain2");
        rd(A_STAT, 32'h04, "stat_tx_done");

        // RX overrun
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1'b1; rx_data_out = 8'h10 + 8'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rd(A_STAT, 32'h27, "stat_rx_ovr");
        for (int i = 0; i < 8; i++) rd(A_DATA, 32'h10 + 32'(i), "rx_data");
        rd(A_DATA, 32'h0, "rx_empty_read");
        rd(A_STAT, 32'h24, "stat_ovr_sticky");
        wr(A_STAT, 32'h20);
        rd(A_STAT, 32'h04, "stat_ovr_clr");

        // RX interrupt
        wr(A_CTRL, 32'h07);
        rx_inject(8'h5A);
        @(negedge clk);
        check("irq_rx", 32'(irq), 32'd1);
        rd(A_DATA, 32'h5A, "rx_irq_data");
        @(negedge clk);
        check("irq_rx_clr", 32'(irq), 32'd0);
        wr(A_CTRL, 32'h03);

        // RX push on full FIFO together with a CPU pop
        for (int i = 0; i < 8; i++) rx_inject(8'h20 + 8'(i));
        rd(A_STAT, 32'h07, "stat_rx_full");
        bus_cycle(1'b0, 1'b1, A_DATA, 32'd0, 32'h20, "rx_sim_pop", 1'b1, 8'hAA);
        rd(A_STAT, 32'h07, "stat_sim_no_ovr");
        for (int i = 1; i < 8; i++) rd(A_DATA, 32'h20 + 32'(i), "rx_sim_data");
        rd(A_DATA, 32'hAA, "rx_sim_aa");
        rd(A_STAT, 32'h04, "stat_sim_empty");

        // rx_en=0 ignores input; rx_flush empties the FIFO
        wr(A_CTRL, 32'h01);
        rx_inject(8'h33);
        rd(A_STAT, 32'h04, "stat_rx_dis");
        wr(A_CTRL, 32'h03);
        rx_inject(8'h34);
        rx_inject(8'h35);
        wr(A_CTRL, 32'h23);
        rd(A_STAT, 32'h04, "stat_rx_flush");

        // TX flush while the current byte is draining
        wr_tx(8'h51, 1'b1);
        wr_tx(8'h52, 1'b1);
        wr_tx(8'h53, 1'b1);
        wait_busy("busy_flush");
        wr(A_CTRL, 32'h13);
        tx_q.delete();
        wait_tx_done("tx_flush_done");
        repeat (20) @(negedge clk);
        rd(A_STAT, 32'h04, "stat_tx_flush");
        rd(A_CTRL, 32'h03, "ctrl_flush_sc");

        // Asynchronous reset while draining
        wr(A_BAUD, 32'h100);
        wr_tx(8'h61, 1'b1);
        wr_tx(8'h62, 1'b1);
        wait_busy("busy_rst");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_data", {24'b0, tx_data_in}, 32'd0);
        check("arst_rdata", bus_rdata, 32'd0);
        check("arst_baud", {16'b0, baud_tick_max}, 32'h1B2);
        tx_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_STAT, 32'h04, "stat_post_rst");
        rd(A_BAUD, 32'h1B2, "baud_post_rst");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
